// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch (IF)
// and data-memory (DM) stages of the pipeline. One memory transaction is in
// flight at a time. DM wins simultaneous requests unless IF has already been
// passed over STARVE_LIM times in a row. A watchdog turns a silent memory into
// an error response after TIMEOUT cycles.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request (held until if_valid)
//   if_valid/if_rdata     one-cycle fetch response, 32-bit instruction
//   dm_req/dm_we/dm_addr/dm_wdata   data request (held until dm_valid)
//   dm_valid/dm_rdata     one-cycle data response, 64-bit load data
//   resp_err              marks the current valid pulse as a timeout response
//   mem_err               sticky timeout flag, cleared only by reset
//   mem_en/mem_we         one-cycle memory command strobe and write enable
//   mem_addr/mem_wdata    memory address/data, held from ISSUE until RESP
//   mem_rdata/mem_ready   memory read data and one-cycle completion
//   stall_if/stall_mem    combinational pipeline stalls
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_valid,
    output logic [63:0] dm_rdata,
    output logic        resp_err,
    output logic        mem_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state_reg, state_next;
    logic          owner_dm_reg, owner_dm_next;   // 1 = DM owns the access
    logic          we_reg, we_next;
    logic [63:0]   addr_reg, addr_next;
    logic [63:0]   wdata_reg, wdata_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [SW-1:0] starve_reg, starve_next;
    logic [31:0]   if_rdata_reg, if_rdata_next;
    logic [63:0]   dm_rdata_reg, dm_rdata_next;
    logic          resp_err_reg, resp_err_next;
    logic          mem_err_reg, mem_err_next;

    logic          starve_full;
    logic          grant_dm;

    assign starve_full = (starve_reg == SW'(STARVE_LIM));
    // DM wins unless IF is waiting and has been passed over too often.
    assign grant_dm    = dm_req && !(if_req && starve_full);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            owner_dm_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            timer_reg    <= '0;
            starve_reg   <= '0;
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
            resp_err_reg <= 1'b0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_dm_reg <= owner_dm_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            timer_reg    <= timer_next;
            starve_reg   <= starve_next;
            if_rdata_reg <= if_rdata_next;
            dm_rdata_reg <= dm_rdata_next;
            resp_err_reg <= resp_err_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_dm_next = owner_dm_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        timer_next    = timer_reg;
        starve_next   = starve_reg;
        if_rdata_next = if_rdata_reg;
        dm_rdata_next = dm_rdata_reg;
        resp_err_next = resp_err_reg;
        mem_err_next  = mem_err_reg;

        case (state_reg)
            ST_IDLE: begin
                resp_err_next = 1'b0;
                if (grant_dm) begin
                    owner_dm_next = 1'b1;
                    we_next       = dm_we;
                    addr_next     = dm_addr;
                    wdata_next    = dm_wdata;
                    timer_next    = '0;
                    state_next    = ST_ISSUE;
                    if (if_req && !starve_full) begin
                        starve_next = starve_reg + SW'(1);
                    end
                end else if (if_req) begin
                    owner_dm_next = 1'b0;
                    we_next       = 1'b0;
                    addr_next     = if_addr;
                    wdata_next    = '0;
                    timer_next    = '0;
                    starve_next   = '0;
                    state_next    = ST_ISSUE;
                end
            end

            ST_ISSUE, ST_WAIT: begin
                if (mem_ready) begin
                    // Stores leave the requester's read data untouched.
                    if (!owner_dm_reg) begin
                        if_rdata_next = mem_rdata[31:0];
                    end else if (!we_reg) begin
                        dm_rdata_next = mem_rdata;
                    end
                    resp_err_next = 1'b0;
                    state_next    = ST_RESP;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th silent cycle: give up on the access.
                    resp_err_next = 1'b1;
                    mem_err_next  = 1'b1;
                    state_next    = ST_RESP;
                end else begin
                    timer_next = timer_reg + TW'(1);
                    state_next = ST_WAIT;
                end
            end

            ST_RESP: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_en    = (state_reg == ST_ISSUE);
    assign mem_we    = (state_reg == ST_ISSUE) && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign if_valid  = (state_reg == ST_RESP) && !owner_dm_reg;
    assign dm_valid  = (state_reg == ST_RESP) && owner_dm_reg;
    assign resp_err  = (state_reg == ST_RESP) && resp_err_reg;
    assign mem_err   = mem_err_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_valid;
    logic [63:0] dm_rdata;
    logic        resp_err;
    logic        mem_err;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall_if;
    logic        stall_mem;

    int vectors = 0;
    int miscompares = 0;

    // Bench-side record of the last read data each requester should hold.
    logic [31:0] exp_if_rdata = '0;
    logic [63:0] exp_dm_rdata = '0;

    mem_port_arbiter #(.STARVE_LIM(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .resp_err(resp_err), .mem_err(mem_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    // Advance to the start of the next cycle (just after the rising edge).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if ({mem_en, mem_we, if_valid, dm_valid, resp_err, mem_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {mem_en, mem_we, if_valid, dm_valid, resp_err, mem_err});
        end
        vectors++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 224'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h dm_rdata=%h want all 0",
                     mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        $display("txn reset done");
    endtask

    task automatic test_single_fetch();
        // cycle 0
        if_req = 1'b1; if_addr = 64'h10;
        #1;
        vectors++;
        if (stall_if !== 1'b1 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_c0: stall_if=%b mem_en=%b want 1 0", stall_if, mem_en);
        end
        // cycle 1: ISSUE with immediate ready
        step();
        mem_ready = 1'b1; mem_rdata = 64'h8B020020;
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h10 || stall_if !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_issue: en=%b we=%b addr=%h stall_if=%b want 1 0 10 1",
                     mem_en, mem_we, mem_addr, stall_if);
        end
        // cycle 2: RESP
        step();
        mem_ready = 1'b0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_if_rdata = 32'h8B020020;
        #1;
        vectors++;
        if (if_valid !== 1'b1 || if_rdata !== exp_if_rdata || stall_if !== 1'b0 ||
            dm_valid !== 1'b0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_resp: if_valid=%b if_rdata=%h stall_if=%b dm_valid=%b resp_err=%b want 1 %h 0 0 0",
                     if_valid, if_rdata, stall_if, dm_valid, resp_err, exp_if_rdata);
        end
        if_req = 1'b0;
        step();  // back in IDLE
        vectors++;
        if (if_valid !== 1'b0 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_after: if_valid=%b mem_en=%b want 0 0", if_valid, mem_en);
        end
        $display("txn fetch addr=10 rdata=%h", if_rdata);
    endtask

    task automatic test_simultaneous();
        // cycle 0: both request, starve count is 0
        if_req = 1'b1; if_addr = 64'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h20;
        #1;
        vectors++;
        if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_stalls_c0: stall_if=%b stall_mem=%b want 1 1", stall_if, stall_mem);
        end
        step();  // cycle 1
        mem_ready = 1'b1; mem_rdata = 64'h1122334455667788;
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_addr !== 64'h20) begin
            miscompares++;
            $display("FAIL sim_dm_first: en=%b addr=%h want 1 20", mem_en, mem_addr);
        end
        step();  // cycle 2
        mem_ready = 1'b0;
        exp_dm_rdata = 64'h1122334455667788;
        #1;
        vectors++;
        if (dm_valid !== 1'b1 || dm_rdata !== exp_dm_rdata || if_valid !== 1'b0 ||
            stall_if !== 1'b1 || stall_mem !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_dm_resp: dm_valid=%b dm_rdata=%h if_valid=%b stall_if=%b stall_mem=%b",
                     dm_valid, dm_rdata, if_valid, stall_if, stall_mem);
        end
        dm_req = 1'b0;
        step();  // cycle 3: IDLE
        vectors++;
        if (mem_en !== 1'b0 || stall_if !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_idle_c3: en=%b stall_if=%b want 0 1", mem_en, stall_if);
        end
        step();  // cycle 4: IF issued
        mem_ready = 1'b1; mem_rdata = 64'hAAAABBBB00001111;
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_addr !== 64'h40 || mem_we !== 1'b0 || stall_if !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_if_issue: en=%b addr=%h we=%b stall_if=%b want 1 40 0 1",
                     mem_en, mem_addr, mem_we, stall_if);
        end
        step();  // cycle 5
        mem_ready = 1'b0;
        exp_if_rdata = 32'h00001111;
        #1;
        vectors++;
        if (if_valid !== 1'b1 || if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
            miscompares++;
            $display("FAIL sim_if_resp: if_valid=%b if_rdata=%h dm_rdata=%h want 1 %h %h",
                     if_valid, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
        end
        if_req = 1'b0;
        step();
        $display("txn simultaneous dm=20 then if=40");
    endtask

    task automatic test_starvation();
        logic        exp_dm;
        logic [63:0] exp_addr;
        if_req = 1'b1; if_addr = 64'h100;
        dm_req = 1'b1; dm_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            // IDLE cycle: DM presents a fresh load each time
            dm_addr  = 64'h200 + 64'(k * 8);
            exp_dm   = (k != 4);
            exp_addr = exp_dm ? 64'h200 + 64'(k * 8) : 64'h100;
            step();  // ISSUE
            mem_ready = 1'b1;
            mem_rdata = 64'h5A5A000000000000 | 64'(32'hC0DE0000 + k);
            #1;
            vectors++;
            if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin
                miscompares++;
                $display("FAIL starve_grant%0d: en=%b addr=%h want 1 %h", k, mem_en, mem_addr, exp_addr);
            end
            if (exp_dm) exp_dm_rdata = mem_rdata;
            else        exp_if_rdata = mem_rdata[31:0];
            step();  // RESP
            mem_ready = 1'b0;
            #1;
            vectors++;
            if (dm_valid !== exp_dm || if_valid !== !exp_dm ||
                dm_rdata !== exp_dm_rdata || if_rdata !== exp_if_rdata) begin
                miscompares++;
                $display("FAIL starve_resp%0d: dm_valid=%b if_valid=%b dm_rdata=%h if_rdata=%h want %b %b %h %h",
                         k, dm_valid, if_valid, dm_rdata, if_rdata, exp_dm, !exp_dm, exp_dm_rdata, exp_if_rdata);
            end
            $display("txn starve k=%0d owner=%s addr=%h", k, exp_dm ? "DM" : "IF", exp_addr);
            step();  // IDLE
        end
        if_req = 1'b0; dm_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h8; dm_wdata = 64'hDEADBEEF;
        step();  // cycle 1: ISSUE
        // Later changes must not disturb the latched command.
        dm_addr = 64'h999; dm_wdata = 64'h1;
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 64'hDEADBEEF || mem_addr !== 64'h8) begin
            miscompares++;
            $display("FAIL store_issue: en=%b we=%b wdata=%h addr=%h want 1 1 deadbeef 8",
                     mem_en, mem_we, mem_wdata, mem_addr);
        end
        step();  // cycle 2: WAIT
        step();  // cycle 3: WAIT
        vectors++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || dm_valid !== 1'b0 || mem_addr !== 64'h8 ||
            mem_wdata !== 64'hDEADBEEF || stall_mem !== 1'b1) begin
            miscompares++;
            $display("FAIL store_wait: en=%b we=%b dm_valid=%b addr=%h wdata=%h stall_mem=%b",
                     mem_en, mem_we, dm_valid, mem_addr, mem_wdata, stall_mem);
        end
        step();  // cycle 4: ready
        mem_ready = 1'b1; mem_rdata = 64'hFFFF0000FFFF0000;
        #1;
        vectors++;
        if (dm_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL store_early_valid: got %b want 0", dm_valid);
        end
        step();  // cycle 5: RESP
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (dm_valid !== 1'b1 || resp_err !== 1'b0 || dm_rdata !== exp_dm_rdata) begin
            miscompares++;
            $display("FAIL store_resp: dm_valid=%b resp_err=%b dm_rdata=%h want 1 0 %h",
                     dm_valid, resp_err, dm_rdata, exp_dm_rdata);
        end
        dm_req = 1'b0; dm_we = 1'b0;
        step();  // cycle 6
        vectors++;
        if (dm_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL store_pulse: dm_valid=%b want 0", dm_valid);
        end
        $display("txn store addr=8 wdata=deadbeef");
    endtask

    task automatic test_timeout();
        int early_valid;
        early_valid = 0;
        if_req = 1'b1; if_addr = 64'h300;
        step();  // cycle 1: ISSUE
        for (int c = 2; c <= 64; c++) begin
            if (if_valid !== 1'b0 || mem_err !== 1'b0) early_valid++;
            step();
        end
        // now in cycle 64
        vectors++;
        if (early_valid != 0 || if_valid !== 1'b0 || mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: early=%0d if_valid=%b mem_err=%b want 0 0 0",
                     early_valid, if_valid, mem_err);
        end
        step();  // cycle 65
        vectors++;
        if (if_valid !== 1'b1 || resp_err !== 1'b1 || mem_err !== 1'b1 || if_rdata !== exp_if_rdata) begin
            miscompares++;
            $display("FAIL timeout_resp: if_valid=%b resp_err=%b mem_err=%b if_rdata=%h want 1 1 1 %h",
                     if_valid, resp_err, mem_err, if_rdata, exp_if_rdata);
        end
        if_req = 1'b0;
        step();  // cycle 66
        vectors++;
        if (if_valid !== 1'b0 || resp_err !== 1'b0 || mem_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: if_valid=%b resp_err=%b mem_err=%b want 0 0 1",
                     if_valid, resp_err, mem_err);
        end
        $display("txn timeout fetch addr=300");
    endtask

    task automatic test_reset_in_wait();
        int stray;
        stray = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h400;
        step();  // cycle 1: ISSUE
        step();  // cycle 2: WAIT
        reset = 1'b1; dm_req = 1'b0;
        step();  // cycle 3
        reset = 1'b0;
        #1;
        vectors++;
        if ({mem_en, mem_we, if_valid, dm_valid, resp_err, mem_err} !== 6'b0 ||
            {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 224'h0) begin
            miscompares++;
            $display("FAIL rst_wait_outputs: flags=%b addr=%h wdata=%h if_rdata=%h dm_rdata=%h want all 0",
                     {mem_en, mem_we, if_valid, dm_valid, resp_err, mem_err},
                     mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        mem_ready = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
        step();
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (if_valid !== 1'b0 || dm_valid !== 1'b0 || mem_en !== 1'b0) stray++;
            step();
        end
        vectors++;
        if (stray != 0 || dm_rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_wait_stale: stray=%0d dm_rdata=%h want 0 0", stray, dm_rdata);
        end
        $display("txn reset during wait");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_timeout();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipelined CPU. Arbitrates requests and drives a single memory transaction at a time with a variable-latency ready handshake. Returns responses and stall signals to the pipeline. Data accesses have priority, with a starvation guard for fetch and a watchdog timeout.

Parameters:
STARVE_LIM, 4, max consecutive DM grants while if_req is pending before IF is forced
TIMEOUT, 64, cycles in ISSUE/WAIT without mem_ready before an error response

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held until if_valid
if_addr  input  64  fetch byte address
if_valid  output  1  one-cycle fetch response pulse
if_rdata  output  32  fetched instruction (mem_rdata[31:0])
dm_req  input  1  data request, held until dm_valid
dm_we  input  1  1 = store, 0 = load
dm_addr  input  64  data byte address
dm_wdata  input  64  store data
dm_valid  output  1  one-cycle data response pulse
dm_rdata  output  64  load data
resp_err  output  1  qualifies the current valid pulse as a timeout response
mem_err  output  1  sticky timeout flag
mem_en  output  1  memory command strobe, one cycle per access
mem_we  output  1  memory write enable, valid with mem_en
mem_addr  output  64  memory address, held from ISSUE until RESP
mem_wdata  output  64  memory write data, held from ISSUE until RESP
mem_rdata  input  64  memory read data, valid when mem_ready=1
mem_ready  input  1  memory completion, one cycle
stall_if  output  1  if_req & ~if_valid (combinational)
stall_mem  output  1  dm_req & ~dm_valid (combinational)

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset state: IDLE. Reset values:
  - mem_en, mem_we, if_valid, dm_valid, resp_err, mem_err = 0
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0
  - starve_cnt = 0, timer = 0
- All outputs except stall_if and stall_mem are registered or decoded from the state register (Moore).
- FSM states: IDLE, ISSUE, WAIT, RESP. Each state is defined below.
- IDLE:
  - Sample both requests.
  - Only one request high: grant it.
  - Both high: grant DM, unless starve_cnt == STARVE_LIM, then grant IF.
  - On a grant, latch owner, address, we and wdata; go to ISSUE.
  - IF accesses always have mem_we = 0.
  - No request: stay in IDLE.
- ISSUE:
  - mem_en = 1 for exactly this cycle; timer cleared on entry.
  - mem_ready = 1 here: go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - mem_ready = 1: go to RESP.
  - Otherwise timer increments.
- Timeout:
  - TIMEOUT consecutive ISSUE/WAIT cycles without mem_ready: go to RESP with resp_err = 1 and mem_err set.
  - mem_err stays set until reset.
- RESP:
  - The owner's valid = 1 for exactly this cycle, then go to IDLE.
  - Load or fetch: rdata is captured from mem_rdata on the ready cycle.
  - Store or timeout: the owner's rdata holds its previous value.
  - The requester drops req or presents a new request at the end of the RESP cycle. The arbiter never re-samples req during RESP.
- Latency: request seen in IDLE at cycle 0 with mem_ready in ISSUE gives valid in cycle 2 (minimum). Back-to-back accesses are 3 cycles apart minimum.
- starve_cnt:
  - Increments on each DM grant made while if_req = 1, saturating at STARVE_LIM.
  - Clears to 0 on any IF grant.
- mem_ready is ignored in IDLE and RESP, including stale completions after reset.
- Request inputs may change only in IDLE-visible cycles. The owner's address and data are latched, so later changes have no effect.
- Reset mid-transaction: next cycle is IDLE with all outputs at reset values. The outstanding access is abandoned and no valid pulse is produced.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x10 at cycle 0; mem_ready = 1 with mem_rdata = 0x8B020020 in cycle 1 -> cycle 1: mem_en = 1, mem_we = 0, mem_addr = 0x10; cycle 2: if_valid = 1, if_rdata = 0x8B020020; stall_if high in cycles 0–1, low in cycle 2.
- Simultaneous requests, starve_cnt = 0: both asserted, memory ready after 1 cycle -> DM issued first, dm_valid in cycle 2; IF issued in cycle 4, if_valid in cycle 5; stall_if high through cycle 4.
- Starvation: dm_req held continuously (new loads each time), if_req held -> exactly 4 DM grants, then an IF grant; starve_cnt returns to 0 and the next grant goes to DM.
- Store: dm_we = 1, dm_addr = 0x8, dm_wdata = 0xDEADBEEF, mem_ready 3 cycles after ISSUE -> mem_en = 1, mem_we = 1, mem_wdata = 0xDEADBEEF in ISSUE; single dm_valid pulse; dm_rdata unchanged; resp_err = 0.
- Timeout: IF issued in cycle 1, mem_ready never asserted -> RESP in cycle 65 with if_valid = 1, resp_err = 1; mem_err = 1 from cycle 65 until reset.
- Reset in WAIT: reset asserted for one cycle in WAIT -> next cycle IDLE, all outputs 0; mem_ready = 1 pulsed afterwards produces no valid pulse.
